// File: rtl/piso_pkg.sv
// Shared types and constants for the framed parallel-in serial-out transmitter.
package piso_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic SOUT_IDLE = 1'b1;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts 0..DIV-1 and strobes bit_end on the last clock of each bit.
module bit_tick_gen
  import piso_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CW = cnt_width(DIV);
  localparam logic [CW-1:0] CntMax = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_end = (cnt_q == CntMax);
    cnt_d   = cnt_q + CW'(1);
    // Accept restarts the period so the start bit is exactly DIV clocks long.
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_frame_tx.sv
// Framed serial transmitter: start bit, LSB-first data, optional even parity, stop bit.
module piso_frame_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV       = 4,
  parameter int unsigned PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW = $clog2(WIDTH) + 1;
  localparam logic [BW-1:0] LastBit = BW'(WIDTH - 1);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             par_q, par_d;
  logic             done_q, done_d;
  logic             accept;
  logic             bit_end;

  assign accept = (state_q == IDLE) && din_valid;

  bit_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shift_d   = din;
          par_d     = ^din;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LastBit) begin
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
            bit_cnt_d = '0;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      done_q    <= done_d;
    end
  end

  // Line level decoded purely from registered state.
  always_comb begin
    sout = SOUT_IDLE;
    unique case (state_q)
      START:   sout = 1'b0;
      DATA:    sout = shift_q[0];
      PARITY:  sout = par_q;
      default: sout = SOUT_IDLE;
    endcase
  end

  assign din_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_piso_frame_tx.sv
// Directed bench for piso_frame_tx across three parameterisations.
module tb_piso_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din       [3];
  logic       din_valid [3];
  logic       din_ready [3];
  logic       sout      [3];
  logic       busy      [3];
  logic       done      [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_frame_tx #(.WIDTH(8), .DIV(4), .PARITY_EN(1)) dut_a (
    .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid[0]),
    .din_ready(din_ready[0]), .sout(sout[0]), .busy(busy[0]), .done(done[0])
  );

  piso_frame_tx #(.WIDTH(8), .DIV(1), .PARITY_EN(1)) dut_b (
    .clk(clk), .rst(rst), .din(din[1]), .din_valid(din_valid[1]),
    .din_ready(din_ready[1]), .sout(sout[1]), .busy(busy[1]), .done(done[1])
  );

  piso_frame_tx #(.WIDTH(8), .DIV(4), .PARITY_EN(0)) dut_c (
    .clk(clk), .rst(rst), .din(din[2]), .din_valid(din_valid[2]),
    .din_ready(din_ready[2]), .sout(sout[2]), .busy(busy[2]), .done(done[2])
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Sends d on instance s starting at a negedge and checks every cycle of the frame.
  // At cycle next_at the next word nxt is presented; next_at < 0 means none.
  task automatic run_frame(input int s, input logic [7:0] d, input int div, input int pen,
                           input int next_at, input logic [7:0] nxt);
    int   nb;
    int   b;
    logic eb;
    nb           = 10 + pen;
    din[s]       = d;
    din_valid[s] = 1'b1;
    chk($sformatf("s%0d %h ready_pre", s, d), din_ready[s], 1'b1);
    @(posedge clk);
    @(negedge clk);
    din_valid[s] = 1'b0;
    for (int k = 0; k < nb * div; k++) begin
      b = k / div;
      if (k == next_at) begin
        din[s]       = nxt;
        din_valid[s] = 1'b1;
      end
      if (b == 0)                  eb = 1'b0;
      else if (b <= 8)             eb = d[b-1];
      else if (b == 9 && pen != 0) eb = ^d;
      else                         eb = 1'b1;
      chk($sformatf("s%0d %h cyc%0d sout", s, d, k), sout[s], eb);
      chk($sformatf("s%0d %h cyc%0d busy", s, d, k), busy[s], 1'b1);
      chk($sformatf("s%0d %h cyc%0d done", s, d, k), done[s], 1'b0);
      chk($sformatf("s%0d %h cyc%0d ready", s, d, k), din_ready[s], 1'b0);
      @(negedge clk);
    end
    chk($sformatf("s%0d %h end done", s, d), done[s], 1'b1);
    chk($sformatf("s%0d %h end busy", s, d), busy[s], 1'b0);
    chk($sformatf("s%0d %h end ready", s, d), din_ready[s], 1'b1);
    chk($sformatf("s%0d %h end sout", s, d), sout[s], 1'b1);
    if (next_at < 0) begin
      @(negedge clk);
      chk($sformatf("s%0d %h done_drop", s, d), done[s], 1'b0);
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din[i]       = 8'h00;
      din_valid[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("s%0d reset sout", i), sout[i], 1'b1);
      chk($sformatf("s%0d reset ready", i), din_ready[i], 1'b1);
      chk($sformatf("s%0d reset busy", i), busy[i], 1'b0);
      chk($sformatf("s%0d reset done", i), done[i], 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);

    // Basic frame, odd-parity data with DIV=1, parity disabled.
    run_frame(0, 8'hA5, 4, 1, -1, 8'h00);
    run_frame(1, 8'h01, 1, 1, -1, 8'h00);
    run_frame(2, 8'hFF, 4, 0, -1, 8'h00);

    // Back-to-back with valid held and din changing mid-frame.
    run_frame(0, 8'h3C, 4, 1, 0, 8'hC3);
    run_frame(0, 8'hC3, 4, 1, -1, 8'h00);

    // Reset during DATA bit 3 (cycles 16..19 after accept).
    din[0]       = 8'hA5;
    din_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din_valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("rst_mid pre sout", sout[0], 1'b0);
    chk("rst_mid pre busy", busy[0], 1'b1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_mid sout", sout[0], 1'b1);
    chk("rst_mid busy", busy[0], 1'b0);
    chk("rst_mid ready", din_ready[0], 1'b1);
    chk("rst_mid done", done[0], 1'b0);
    for (int k = 0; k < 50; k++) begin
      chk($sformatf("rst_mid idle%0d done", k), done[0], 1'b0);
      chk($sformatf("rst_mid idle%0d sout", k), sout[0], 1'b1);
      @(negedge clk);
    end
    run_frame(0, 8'h5A, 4, 1, -1, 8'h00);

    // New word presented during STOP is held off until IDLE.
    run_frame(0, 8'h96, 4, 1, 40, 8'h69);
    run_frame(0, 8'h69, 4, 1, -1, 8'h00);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("after idle%0d busy", k), busy[0], 1'b0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
